led_counter_ctrl: RTL
=====================

# led_counter_ctrl

Parametrised successor to the board-level LED counter: a WIDTH-bit up/down counter driven by an asynchronous push-button level. The count input is synchronised and rising-edge detected inside the block. Supports a programmable terminal value LIMIT, wrap or saturate modes, synchronous clear and parallel load, and a terminal-count pulse. It sits between the board pins and the LED driver in every board top.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (1..32).
- LIMIT, 2**WIDTH-1, terminal value; count range is 0..LIMIT.
- SYNC_STAGES, 2, synchroniser depth for count_i (>=2).

Ports:
- clock_i  in  1  single clock; every register is on its rising edge.
- clear_i  in  1  reset, asynchronous, active-high.
- sclr_i  in  1  synchronous clear to 0.
- count_i  in  1  asynchronous button level; each rising edge requests one step.
- mode_i  in  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 down-saturate.
- load_i  in  1  synchronous parallel load strobe.
- load_value_i  in  WIDTH  load value.
- q_o  out  WIDTH  counter value, registered.
- tc_o  out  1  one-cycle terminal-count pulse, registered.
- sat_o  out  1  high while in a saturate mode and q_o equals its terminal value.

sclr_i, mode_i, load_i and load_value_i are synchronous to clock_i.

## Operation
- **Reset (clear_i high):**
  - q_o = 0 and tc_o = 0.
  - Synchroniser stages and the edge-detect history register reset to 1, so a button held through reset release produces no step.
  - sat_o follows its combinational definition, so it equals 1 under mode 11 and 0 otherwise.
- **Step pulse:** asserted for one cycle when synchroniser output = 1 and history = 0.
- **Per-edge priority:** clear_i (async) > sclr_i > load_i > step.
  - A step that coincides with sclr_i or load_i is dropped.
- **Load:**
  - q_o <= min(load_value_i, LIMIT).
  - tc_o stays 0 on load and sclr.
- **Up-wrap step:** q_o = LIMIT -> 0 with tc_o = 1; otherwise q_o + 1.
- **Down-wrap step:** q_o = 0 -> LIMIT with tc_o = 1; otherwise q_o - 1.
- **Up-saturate step:**
  - q_o < LIMIT -> q_o + 1; tc_o = 1 only if the new value equals LIMIT.
  - At LIMIT: no change, no pulse.
- **Down-saturate step:** mirror of up-saturate, with terminal value 0.
- **Mode change:** never alters q_o; it applies from the next step.
- **Out-of-range value:** if q_o > LIMIT (only possible after a WIDTH/LIMIT misconfiguration), the next step loads 0 for up modes and LIMIT for down modes.
- **Arithmetic:** all arithmetic is WIDTH bits unsigned; LIMIT is compared at WIDTH bits.
- **sat_o:** combinational from q_o and mode_i: (mode_i = 10 and q_o = LIMIT) or (mode_i = 11 and q_o = 0).

## Timing
- **Step latency:**
  - count_i first sampled high at edge k gives a step pulse in the cycle after edge k+SYNC_STAGES-1.
  - q_o updates at edge k+SYNC_STAGES; the default (SYNC_STAGES = 2) is edge k+2.
- **tc_o:** asserted in the same cycle q_o takes the terminal/wrapped value; deasserted after one cycle.
- **Load/sclr:** q_o updates one edge after load_i/sclr_i is sampled high.
- **Button held high:** exactly one step.
- **Glitch:** a pulse of one cycle that is sampled high produces at most one step.
- **clear_i asserted mid-operation:** q_o = 0 and tc_o = 0 immediately, without waiting for a clock edge.
- **After clear_i release:** the first step requires count_i observed low, then high.
- **Back-to-back steps:** count_i toggling every cycle gives at most one step per two cycles.

## Structure
- **Shared header counter_defs.vh:**
  - mode encodings MODE_UP_WRAP, MODE_DOWN_WRAP, MODE_UP_SAT, MODE_DOWN_SAT.
  - default WIDTH and SYNC_STAGES.
- **Sub-module edge_sync:**
  - ports: clock_i, clear_i, async_i, pulse_o.
  - SYNC_STAGES-deep synchroniser with a preset-to-1 history register and rising-edge detect.
  - Reused by future button inputs.
- **Top:** led_counter_ctrl holds the counter/priority logic, the tc_o register and the sat_o decode.

## Test plan
- **Reset and basic count** (WIDTH=8, LIMIT=9, mode 00): clear_i pulse, then 3 button presses -> q_o = 0, then 3; each step lands exactly 2 edges after count_i is first sampled high.
- **Up-wrap:** load 9, one press -> q_o = 0, tc_o high for exactly 1 cycle; mode 01 from 0, one press -> q_o = 9, tc_o pulse.
- **Saturate:**
  - Mode 10: load 8, press -> q_o = 9, tc_o pulse, sat_o = 1; press again -> q_o = 9, no tc_o.
  - Mode 11 at 0: sat_o = 1.
- **Priority and clamp:**
  - load_i with load_value_i = 200 -> q_o = 9.
  - A step coinciding with load_i is dropped.
  - A step coinciding with sclr_i -> q_o = 0.
- **Reset corner cases:**
  - count_i held high across clear_i release -> no step.
  - clear_i asserted between clock edges mid-count -> q_o = 0 immediately.
- **Glitch and hold:** count_i held high for 50 cycles -> one step; count_i toggling every cycle for 20 cycles -> q_o advances by no more than 10.

Source files
------------

// File: rtl/led_counter_ctrl_pkg.sv
// Shared definitions for the LED counter controller and its button front end.
package led_counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'b00,
        MODE_DOWN_WRAP = 2'b01,
        MODE_UP_SAT    = 2'b10,
        MODE_DOWN_SAT  = 2'b11
    } mode_e;

endpackage

// File: rtl/led_counter_ctrl_if.sv
// Control/status bundle between the board top (master) and the counter (slave).
interface led_counter_ctrl_if
    import led_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             sclr_i;
    logic             count_i;
    mode_e            mode_i;
    logic             load_i;
    logic [WIDTH-1:0] load_value_i;
    logic [WIDTH-1:0] q_o;
    logic             tc_o;
    logic             sat_o;

    modport master (
        output sclr_i, count_i, mode_i, load_i, load_value_i,
        input  q_o, tc_o, sat_o
    );

    modport slave (
        input  sclr_i, count_i, mode_i, load_i, load_value_i,
        output q_o, tc_o, sat_o
    );

endinterface

// File: rtl/led_counter_ctrl_edge_sync.sv
// Multi-stage synchroniser with rising-edge detect for asynchronous button levels.
// Everything presets to 1 so a level held through reset release never steps.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock_i,
    input  logic clear_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/led_counter_ctrl.sv
// Up/down LED counter with wrap/saturate modes, clamped load and terminal-count pulse.
module led_counter_ctrl
    import led_counter_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH       = DEFAULT_WIDTH,
    parameter longint unsigned LIMIT       = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic               clock_i,
    input  logic               clear_i,
    led_counter_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             step;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_next;
    logic             tc_q;
    logic             tc_next;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_count_sync (
        .clock_i (clock_i),
        .clear_i (clear_i),
        .async_i (bus.count_i),
        .pulse_o (step)
    );

    // Priority: sclr > load > step; out-of-range values recover to the mode's start point.
    always_comb begin
        q_next  = q_q;
        tc_next = 1'b0;
        if (bus.sclr_i) begin
            q_next = '0;
        end else if (bus.load_i) begin
            q_next = (bus.load_value_i > LIM) ? LIM : bus.load_value_i;
        end else if (step) begin
            case (bus.mode_i)
                MODE_UP_WRAP: begin
                    if (q_q > LIM) begin
                        q_next = '0;
                    end else if (q_q == LIM) begin
                        q_next  = '0;
                        tc_next = 1'b1;
                    end else begin
                        q_next = q_q + ONE;
                    end
                end
                MODE_DOWN_WRAP: begin
                    if (q_q > LIM) begin
                        q_next = LIM;
                    end else if (q_q == '0) begin
                        q_next  = LIM;
                        tc_next = 1'b1;
                    end else begin
                        q_next = q_q - ONE;
                    end
                end
                MODE_UP_SAT: begin
                    if (q_q > LIM) begin
                        q_next = '0;
                    end else if (q_q != LIM) begin
                        q_next  = q_q + ONE;
                        tc_next = ((q_q + ONE) == LIM);
                    end
                end
                MODE_DOWN_SAT: begin
                    if (q_q > LIM) begin
                        q_next = LIM;
                    end else if (q_q != '0) begin
                        q_next  = q_q - ONE;
                        tc_next = (q_q == ONE);
                    end
                end
                default: q_next = q_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_next;
            tc_q <= tc_next;
        end
    end

    assign bus.q_o   = q_q;
    assign bus.tc_o  = tc_q;
    assign bus.sat_o = ((bus.mode_i == MODE_UP_SAT)   && (q_q == LIM)) ||
                       ((bus.mode_i == MODE_DOWN_SAT) && (q_q == '0));

endmodule
